// File: rtl/mips_ctrl_decoder.sv
// rtl/mips_ctrl_decoder.sv - registered MIPS main control and ALU-op decoder
// Optional out_Illegal flag for unsupported encodings under `define CTRL_ILLEGAL_FLAG_EN.
module mips_ctrl_decoder (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Func,
  output logic       out_MemWrite,
  output logic       out_RegWrite,
  output logic       out_MemToReg,
  output logic       out_ExtendType,
  output logic       out_AluSrc,
  output logic       out_RegDst,
  output logic       out_Branch,
  output logic       out_Shift_16bit,
  output logic       out_JL,
  output logic       out_Halfword,
  output logic       out_Byte,
  output logic       out_J,
  output logic       out_Jr,
  output logic [3:0] out_ALU_Ctr
`ifdef CTRL_ILLEGAL_FLAG_EN
  ,
  output logic       out_Illegal
`endif
);

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_NOR  = 4'b0101;
  localparam logic [3:0] ALU_SLT  = 4'b0110;
  localparam logic [3:0] ALU_SLTU = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_SRA  = 4'b1010;

  logic       mem_write, reg_write, mem_to_reg, extend_type, alu_src, reg_dst;
  logic       branch, shift_16, jl, halfword, byte_acc, jump, jump_reg, illegal;
  logic [3:0] alu_ctr;

  always_comb begin
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = 1'b0;
    extend_type = 1'b0;
    alu_src     = 1'b0;
    reg_dst     = 1'b0;
    branch      = 1'b0;
    shift_16    = 1'b0;
    jl          = 1'b0;
    halfword    = 1'b0;
    byte_acc    = 1'b0;
    jump        = 1'b0;
    jump_reg    = 1'b0;
    illegal     = 1'b0;
    alu_ctr     = ALU_ADD;
    case (Op)
      6'b000000: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        case (Func)
          6'b100000, 6'b100001: alu_ctr = ALU_ADD;
          6'b100010, 6'b100011: alu_ctr = ALU_SUB;
          6'b100100: alu_ctr = ALU_AND;
          6'b100101: alu_ctr = ALU_OR;
          6'b100110: alu_ctr = ALU_XOR;
          6'b100111: alu_ctr = ALU_NOR;
          6'b101010: alu_ctr = ALU_SLT;
          6'b101011: alu_ctr = ALU_SLTU;
          6'b000000: alu_ctr = ALU_SLL;
          6'b000010: alu_ctr = ALU_SRL;
          6'b000011: alu_ctr = ALU_SRA;
          6'b001000: begin
            reg_write = 1'b0;
            reg_dst   = 1'b0;
            jump_reg  = 1'b1;
          end
          default: begin
            reg_write = 1'b0;
            reg_dst   = 1'b0;
            illegal   = 1'b1;
          end
        endcase
      end
      6'b001000, 6'b001001: begin reg_write = 1'b1; alu_src = 1'b1; extend_type = 1'b1; end
      6'b001010: begin reg_write = 1'b1; alu_src = 1'b1; extend_type = 1'b1; alu_ctr = ALU_SLT; end
      6'b001011: begin reg_write = 1'b1; alu_src = 1'b1; extend_type = 1'b1; alu_ctr = ALU_SLTU; end
      6'b001100: begin reg_write = 1'b1; alu_src = 1'b1; alu_ctr = ALU_AND; end
      6'b001101: begin reg_write = 1'b1; alu_src = 1'b1; alu_ctr = ALU_OR; end
      6'b001110: begin reg_write = 1'b1; alu_src = 1'b1; alu_ctr = ALU_XOR; end
      6'b001111: begin reg_write = 1'b1; alu_src = 1'b1; shift_16 = 1'b1; end
      // Loads and stores share address generation: sign-extended offset plus base.
      6'b100011, 6'b100001, 6'b100000: begin
        reg_write   = 1'b1;
        alu_src     = 1'b1;
        mem_to_reg  = 1'b1;
        extend_type = 1'b1;
        halfword    = (Op == 6'b100001);
        byte_acc    = (Op == 6'b100000);
      end
      6'b101011, 6'b101001, 6'b101000: begin
        mem_write   = 1'b1;
        alu_src     = 1'b1;
        extend_type = 1'b1;
        halfword    = (Op == 6'b101001);
        byte_acc    = (Op == 6'b101000);
      end
      6'b000100: begin branch = 1'b1; extend_type = 1'b1; alu_ctr = ALU_SUB; end
      6'b000010: jump = 1'b1;
      6'b000011: begin jump = 1'b1; jl = 1'b1; reg_write = 1'b1; end
      default: illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_MemWrite    <= 1'b0;
      out_RegWrite    <= 1'b0;
      out_MemToReg    <= 1'b0;
      out_ExtendType  <= 1'b0;
      out_AluSrc      <= 1'b0;
      out_RegDst      <= 1'b0;
      out_Branch      <= 1'b0;
      out_Shift_16bit <= 1'b0;
      out_JL          <= 1'b0;
      out_Halfword    <= 1'b0;
      out_Byte        <= 1'b0;
      out_J           <= 1'b0;
      out_Jr          <= 1'b0;
      out_ALU_Ctr     <= 4'b0000;
    end else begin
      out_MemWrite    <= mem_write;
      out_RegWrite    <= reg_write;
      out_MemToReg    <= mem_to_reg;
      out_ExtendType  <= extend_type;
      out_AluSrc      <= alu_src;
      out_RegDst      <= reg_dst;
      out_Branch      <= branch;
      out_Shift_16bit <= shift_16;
      out_JL          <= jl;
      out_Halfword    <= halfword;
      out_Byte        <= byte_acc;
      out_J           <= jump;
      out_Jr          <= jump_reg;
      out_ALU_Ctr     <= alu_ctr;
    end
  end

`ifdef CTRL_ILLEGAL_FLAG_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_Illegal <= 1'b0;
    else        out_Illegal <= illegal;
  end
`else
  logic unused_illegal;
  assign unused_illegal = illegal;
`endif

endmodule

// File: tb/tb_mips_ctrl_decoder.sv
// tb/tb_mips_ctrl_decoder.sv - directed self-checking bench for mips_ctrl_decoder
module tb_mips_ctrl_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] Op, Func;
  logic       out_MemWrite, out_RegWrite, out_MemToReg, out_ExtendType, out_AluSrc, out_RegDst;
  logic       out_Branch, out_Shift_16bit, out_JL, out_Halfword, out_Byte, out_J, out_Jr;
  logic [3:0] out_ALU_Ctr;
`ifdef CTRL_ILLEGAL_FLAG_EN
  logic       out_Illegal;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mips_ctrl_decoder dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Func(Func),
    .out_MemWrite(out_MemWrite), .out_RegWrite(out_RegWrite), .out_MemToReg(out_MemToReg),
    .out_ExtendType(out_ExtendType), .out_AluSrc(out_AluSrc), .out_RegDst(out_RegDst),
    .out_Branch(out_Branch), .out_Shift_16bit(out_Shift_16bit), .out_JL(out_JL),
    .out_Halfword(out_Halfword), .out_Byte(out_Byte), .out_J(out_J), .out_Jr(out_Jr),
    .out_ALU_Ctr(out_ALU_Ctr)
`ifdef CTRL_ILLEGAL_FLAG_EN
    , .out_Illegal(out_Illegal)
`endif
  );

  // Order: MemWrite RegWrite MemToReg ExtendType AluSrc RegDst Branch Shift16 JL Halfword Byte J Jr ALU[3:0]
  function automatic logic [16:0] mk(input logic mw, rw, mr, et, as, rd, br, sh, jl, hw, by, j, jr,
                                     input logic [3:0] alu);
    return {mw, rw, mr, et, as, rd, br, sh, jl, hw, by, j, jr, alu};
  endfunction

  logic [16:0] obs;
  assign obs = {out_MemWrite, out_RegWrite, out_MemToReg, out_ExtendType, out_AluSrc, out_RegDst,
                out_Branch, out_Shift_16bit, out_JL, out_Halfword, out_Byte, out_J, out_Jr, out_ALU_Ctr};

  task automatic check(input string tag, input logic [16:0] exp, input logic exp_ill);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
`ifdef CTRL_ILLEGAL_FLAG_EN
    checks++;
    assert (out_Illegal === exp_ill) else begin
      errors++;
      $error("FAIL %s illegal: observed %b expected %b", tag, out_Illegal, exp_ill);
    end
`else
    if (exp_ill) begin end
`endif
  endtask

  task automatic step(input logic [5:0] op, input logic [5:0] func);
    @(negedge clk);
    Op = op;
    Func = func;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    Op = 6'b100011;
    Func = 6'b000000;
    repeat (3) @(posedge clk);
    #1 check("reset_hold", 17'd0, 1'b0);

    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("lw_after_release", mk(0,1,1,1,1,0,0,0,0,0,0,0,0,4'b0000), 1'b0);

    step(6'b111000, 6'b000000); check("illegal_111000", 17'd0, 1'b1);
    step(6'b111111, 6'b000000); check("illegal_111111", 17'd0, 1'b1);

    step(6'b000000, 6'b100010); check("r_sub",  mk(0,1,0,0,0,1,0,0,0,0,0,0,0,4'b0001), 1'b0);
    step(6'b000000, 6'b101010); check("r_slt",  mk(0,1,0,0,0,1,0,0,0,0,0,0,0,4'b0110), 1'b0);
    step(6'b000000, 6'b000011); check("r_sra",  mk(0,1,0,0,0,1,0,0,0,0,0,0,0,4'b1010), 1'b0);
    step(6'b000000, 6'b001000); check("r_jr",   mk(0,0,0,0,0,0,0,0,0,0,0,0,1,4'b0000), 1'b0);
    step(6'b000000, 6'b100001); check("r_addu", mk(0,1,0,0,0,1,0,0,0,0,0,0,0,4'b0000), 1'b0);
    step(6'b000000, 6'b100111); check("r_nor",  mk(0,1,0,0,0,1,0,0,0,0,0,0,0,4'b0101), 1'b0);
    step(6'b000000, 6'b000000); check("r_sll",  mk(0,1,0,0,0,1,0,0,0,0,0,0,0,4'b1000), 1'b0);
    step(6'b000000, 6'b101011); check("r_sltu", mk(0,1,0,0,0,1,0,0,0,0,0,0,0,4'b0111), 1'b0);
    step(6'b000000, 6'b000001); check("r_bad_func", 17'd0, 1'b1);

    step(6'b101001, 6'b000000); check("sh",  mk(1,0,0,1,1,0,0,0,0,1,0,0,0,4'b0000), 1'b0);
    step(6'b100000, 6'b000000); check("lb",  mk(0,1,1,1,1,0,0,0,0,0,1,0,0,4'b0000), 1'b0);
    step(6'b100001, 6'b000000); check("lh",  mk(0,1,1,1,1,0,0,0,0,1,0,0,0,4'b0000), 1'b0);
    step(6'b101011, 6'b000000); check("sw",  mk(1,0,0,1,1,0,0,0,0,0,0,0,0,4'b0000), 1'b0);
    step(6'b101000, 6'b000000); check("sb",  mk(1,0,0,1,1,0,0,0,0,0,1,0,0,4'b0000), 1'b0);
    step(6'b000011, 6'b000000); check("jal", mk(0,1,0,0,0,0,0,0,1,0,0,1,0,4'b0000), 1'b0);
    step(6'b000100, 6'b000000); check("beq", mk(0,0,0,1,0,0,1,0,0,0,0,0,0,4'b0001), 1'b0);
    step(6'b000010, 6'b000000); check("j",   mk(0,0,0,0,0,0,0,0,0,0,0,1,0,4'b0000), 1'b0);
    step(6'b001000, 6'b000000); check("addi",  mk(0,1,0,1,1,0,0,0,0,0,0,0,0,4'b0000), 1'b0);
    step(6'b001010, 6'b000000); check("slti",  mk(0,1,0,1,1,0,0,0,0,0,0,0,0,4'b0110), 1'b0);
    step(6'b001011, 6'b000000); check("sltiu", mk(0,1,0,1,1,0,0,0,0,0,0,0,0,4'b0111), 1'b0);
    step(6'b001100, 6'b000000); check("andi",  mk(0,1,0,0,1,0,0,0,0,0,0,0,0,4'b0010), 1'b0);
    step(6'b001101, 6'b000000); check("ori",   mk(0,1,0,0,1,0,0,0,0,0,0,0,0,4'b0011), 1'b0);
    step(6'b001110, 6'b000000); check("xori",  mk(0,1,0,0,1,0,0,0,0,0,0,0,0,4'b0100), 1'b0);
    step(6'b001111, 6'b000000); check("lui",   mk(0,1,0,0,1,0,0,1,0,0,0,0,0,4'b0000), 1'b0);

    Op = 6'b101011;
    #3 check("midcycle_op_change_held", mk(0,1,0,0,1,0,0,1,0,0,0,0,0,4'b0000), 1'b0);
    @(posedge clk); #1;
    check("sw_after_edge", mk(1,0,0,1,1,0,0,0,0,0,0,0,0,4'b0000), 1'b0);

    #2 rst_n = 1'b0;
    #1 check("async_reset_midcycle", 17'd0, 1'b0);
    @(posedge clk); #1;
    check("reset_held_over_edge", 17'd0, 1'b0);
    @(negedge clk);
    Op = 6'b000011;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("jal_first_after_release", mk(0,1,0,0,0,0,0,0,1,0,0,1,0,4'b0000), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
